video_crtc_timing: RTL and testbench

- Sequences the CRTC datapath: consumes the live R0..R13 values from video_crtc_reg and generates the MC6845-style character/scanline timing.
- Outputs: memory address (MA), row address (RA), display enable, HSYNC and VSYNC.
- Advances one character per clk_en_i strobe. Feeds the video fetch/shift logic in the video subsystem.

---
 rtl/video_crtc_timing_pkg.sv | 13 +
 rtl/video_crtc_timing_sync_pulse.sv | 46 ++++
 rtl/video_crtc_timing.sv | 171 +++++++++++++++++
 tb/tb_video_crtc_timing.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_crtc_timing_pkg.sv
// Shared types and constants for the CRTC timing generator.
package video_crtc_timing_pkg;

   localparam int CRTC_MA_WIDTH = 14;
   localparam int CRTC_RA_WIDTH = 5;

   typedef enum logic [1:0] {
      CRTC_VS_PRE_FRAME = 2'd0,
      CRTC_VS_ACTIVE    = 2'd1,
      CRTC_VS_ADJUST    = 2'd2
   } crtc_vstate_t;

endpackage

// File: rtl/video_crtc_timing_sync_pulse.sv
// Sync pulse generator: a start strobe raises the pulse, which then lasts
// 'width' steps; a width of zero disables the pulse entirely.
module video_crtc_sync_pulse (
   input  logic       wb_clock_i,
   input  logic       wb_reset_i,
   input  logic       step,
   input  logic       start,
   input  logic [4:0] width,
   output logic       pulse
);
   import video_crtc_timing_pkg::*;

   logic       pulse_r;
   logic [4:0] count_r;
   logic       done_s;
   logic       fire_s;

   assign done_s = (count_r >= width);
   // A start seen while a pulse is still running is ignored, so a long sync spans frames.
   assign fire_s = start && (width != 5'd0) && (!pulse_r || done_s);

   // Pulse state and elapsed-step counter
   always_ff @(posedge wb_clock_i) begin
      if (wb_reset_i) begin
         pulse_r <= 1'b0;
         count_r <= 5'd0;
      end else if (step) begin
         if (fire_s) begin
            pulse_r <= 1'b1;
            count_r <= 5'd1;
         end else if (pulse_r && done_s) begin
            pulse_r <= 1'b0;
            count_r <= 5'd0;
         end else if (pulse_r) begin
            count_r <= count_r + 5'd1;
         end else begin
            count_r <= 5'd0;
         end
      end else begin
         pulse_r <= pulse_r;
      end
   end

   assign pulse = pulse_r;

endmodule

// File: rtl/video_crtc_timing.sv
// MC6845-style character/scanline timing: walks h/row/ra counters per
// character strobe and registers MA, RA, DE and sync outputs.
module video_crtc_timing
   import video_crtc_timing_pkg::*;
#(
   parameter int MA_WIDTH = CRTC_MA_WIDTH
) (
   input  logic                wb_clock_i,
   input  logic                wb_reset_i,
   input  logic                clk_en_i,
   input  logic [7:0]          r0_h_total_i,
   input  logic [7:0]          r1_h_displayed_i,
   input  logic [7:0]          r2_h_sync_pos_i,
   input  logic [3:0]          r3_h_sync_width_i,
   input  logic [4:0]          r3_v_sync_width_i,
   input  logic [6:0]          r4_v_total_i,
   input  logic [4:0]          r5_v_adjust_i,
   input  logic [6:0]          r6_v_displayed_i,
   input  logic [6:0]          r7_v_sync_pos_i,
   input  logic [4:0]          r9_max_scan_line_i,
   input  logic [13:0]         r1213_start_addr_i,
   output logic [MA_WIDTH-1:0] ma_o,
   output logic [4:0]          ra_o,
   output logic                de_o,
   output logic                hsync_o,
   output logic                vsync_o,
   output logic                line_start_o,
   output logic                frame_start_o
);

   crtc_vstate_t          vstate_r, vstate_s;
   logic [7:0]            h_r, h_s;
   logic [6:0]            row_r, row_s;
   logic [4:0]            ra_r, ra_s;
   logic [4:0]            adj_r, adj_s;
   logic [MA_WIDTH-1:0]   row_start_r, row_start_s;
   logic [MA_WIDTH-1:0]   ma_r;
   logic                  de_r, line_start_r, frame_start_r;
   logic                  line_start_s, frame_start_s, new_frame_s, eol_s;
   logic                  de_s, hs_start_s, vs_start_s;

   // Next-state decode for the character and vertical counters
   always_comb begin
      vstate_s      = vstate_r;
      h_s           = h_r;
      row_s         = row_r;
      ra_s          = ra_r;
      adj_s         = adj_r;
      row_start_s   = row_start_r;
      line_start_s  = 1'b0;
      frame_start_s = 1'b0;
      new_frame_s   = 1'b0;
      eol_s         = (h_r >= r0_h_total_i);
      case (vstate_r)
         CRTC_VS_ACTIVE: begin
            if (eol_s) begin
               h_s          = 8'd0;
               line_start_s = 1'b1;
               if (ra_r >= r9_max_scan_line_i) begin
                  row_start_s = row_start_r + MA_WIDTH'(r1_h_displayed_i);
                  if (row_r >= r4_v_total_i) begin
                     if (r5_v_adjust_i != 5'd0) begin
                        vstate_s = CRTC_VS_ADJUST;
                        ra_s     = ra_r + 5'd1;
                        adj_s    = 5'd0;
                     end else begin
                        new_frame_s = 1'b1;
                     end
                  end else begin
                     row_s = row_r + 7'd1;
                     ra_s  = 5'd0;
                  end
               end else begin
                  ra_s = ra_r + 5'd1;
               end
            end else begin
               h_s = h_r + 8'd1;
            end
         end
         CRTC_VS_ADJUST: begin
            if (eol_s) begin
               h_s          = 8'd0;
               line_start_s = 1'b1;
               if (({1'b0, adj_r} + 6'd1) >= {1'b0, r5_v_adjust_i}) begin
                  new_frame_s = 1'b1;
               end else begin
                  adj_s = adj_r + 5'd1;
                  ra_s  = ra_r + 5'd1;
               end
            end else begin
               h_s = h_r + 8'd1;
            end
         end
         default: new_frame_s = 1'b1;
      endcase
      if (new_frame_s) begin
         vstate_s      = CRTC_VS_ACTIVE;
         h_s           = 8'd0;
         row_s         = 7'd0;
         ra_s          = 5'd0;
         adj_s         = 5'd0;
         row_start_s   = MA_WIDTH'(r1213_start_addr_i);
         line_start_s  = 1'b1;
         frame_start_s = 1'b1;
      end else begin
         frame_start_s = 1'b0;
      end
   end

   assign de_s       = (h_s < r1_h_displayed_i) && (row_s < r6_v_displayed_i) &&
                       (vstate_s == CRTC_VS_ACTIVE);
   assign hs_start_s = (h_s == r2_h_sync_pos_i);
   assign vs_start_s = line_start_s && (vstate_s == CRTC_VS_ACTIVE) &&
                       (row_s == r7_v_sync_pos_i) && (ra_s == 5'd0);

   // State and output registers; the one-shot pulses clear between strobes
   always_ff @(posedge wb_clock_i) begin
      if (wb_reset_i) begin
         vstate_r      <= CRTC_VS_PRE_FRAME;
         h_r           <= 8'd0;
         row_r         <= 7'd0;
         ra_r          <= 5'd0;
         adj_r         <= 5'd0;
         row_start_r   <= '0;
         ma_r          <= '0;
         de_r          <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else if (clk_en_i) begin
         vstate_r      <= vstate_s;
         h_r           <= h_s;
         row_r         <= row_s;
         ra_r          <= ra_s;
         adj_r         <= adj_s;
         row_start_r   <= row_start_s;
         ma_r          <= row_start_s + MA_WIDTH'(h_s);
         de_r          <= de_s;
         line_start_r  <= line_start_s;
         frame_start_r <= frame_start_s;
      end else begin
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end
   end

   video_crtc_sync_pulse u_hsync (
      .wb_clock_i (wb_clock_i),
      .wb_reset_i (wb_reset_i),
      .step       (clk_en_i),
      .start      (hs_start_s),
      .width      ({1'b0, r3_h_sync_width_i}),
      .pulse      (hsync_o)
   );

   // Vertical sync is measured in scanlines, so it only steps at line starts.
   video_crtc_sync_pulse u_vsync (
      .wb_clock_i (wb_clock_i),
      .wb_reset_i (wb_reset_i),
      .step       (clk_en_i && line_start_s),
      .start      (vs_start_s),
      .width      (r3_v_sync_width_i),
      .pulse      (vsync_o)
   );

   assign ma_o          = ma_r;
   assign ra_o          = ra_r;
   assign de_o          = de_r;
   assign line_start_o  = line_start_r;
   assign frame_start_o = frame_start_r;

endmodule

// File: tb/tb_video_crtc_timing.sv
// Scoreboard bench for video_crtc_timing: expected characters are queued per
// line/frame from the register settings; a monitor compares on each strobe.
module tb_video_crtc_timing;

   logic        wb_clock_i = 1'b0;
   logic        wb_reset_i;
   logic        clk_en_i;
   logic [7:0]  r0, r1, r2;
   logic [3:0]  r3h;
   logic [4:0]  r3v, r5, r9;
   logic [6:0]  r4, r6, r7;
   logic [13:0] start;
   logic [13:0] ma_o;
   logic [4:0]  ra_o;
   logic        de_o, hsync_o, vsync_o, line_start_o, frame_start_o;

   int checks = 0;
   int errors = 0;
   int vs_left = 0;
   int ls_cnt = 0;
   int fs_cnt = 0;
   bit mon_on = 1'b0;
   logic en_seen = 1'b0;
   logic rst_seen = 1'b0;
   logic [23:0] exp_q[$];
   logic [23:0] last_v = 24'd0;
   logic [23:0] act_v;

   always #5 wb_clock_i = ~wb_clock_i;

   video_crtc_timing #(.MA_WIDTH(14)) dut (
      .wb_clock_i         (wb_clock_i),
      .wb_reset_i         (wb_reset_i),
      .clk_en_i           (clk_en_i),
      .r0_h_total_i       (r0),
      .r1_h_displayed_i   (r1),
      .r2_h_sync_pos_i    (r2),
      .r3_h_sync_width_i  (r3h),
      .r3_v_sync_width_i  (r3v),
      .r4_v_total_i       (r4),
      .r5_v_adjust_i      (r5),
      .r6_v_displayed_i   (r6),
      .r7_v_sync_pos_i    (r7),
      .r9_max_scan_line_i (r9),
      .r1213_start_addr_i (start),
      .ma_o               (ma_o),
      .ra_o               (ra_o),
      .de_o               (de_o),
      .hsync_o            (hsync_o),
      .vsync_o            (vsync_o),
      .line_start_o       (line_start_o),
      .frame_start_o      (frame_start_o)
   );

   assign act_v = {ma_o, ra_o, de_o, hsync_o, vsync_o, line_start_o, frame_start_o};

   task automatic check(string name, logic [23:0] act, logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t: got ma=%h ra=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected ma=%h ra=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                  name, $time, act[23:10], act[9:5], act[4], act[3], act[2], act[1], act[0],
                  exp[23:10], exp[9:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Queue the characters of one line: h = 0..hlast
   task automatic gen_line(int row, int ra, bit act, logic [13:0] rs, bit first, int hlast);
      logic [23:0] e;
      logic [13:0] ma;
      logic [4:0]  ra5;
      bit          vs;
      if (vs_left > 0) vs_left--;
      if (vs_left == 0 && act && row == int'(r7) && ra == 0 && r3v != 5'd0) vs_left = int'(r3v);
      vs  = (vs_left > 0);
      ra5 = 5'(ra);
      for (int h = 0; h <= hlast; h++) begin
         ma = rs + 14'(h);
         e  = {ma, ra5,
               act && (h < int'(r1)) && (row < int'(r6)),
               (r3h != 4'd0) && (h >= int'(r2)) && (h < int'(r2) + int'(r3h)),
               vs, h == 0, first && (h == 0)};
         exp_q.push_back(e);
      end
   endtask

   task automatic gen_frame();
      logic [13:0] rs;
      rs = start;
      for (int row = 0; row <= int'(r4); row++) begin
         for (int ra = 0; ra <= int'(r9); ra++)
            gen_line(row, ra, 1'b1, rs, (row == 0) && (ra == 0), int'(r0));
         rs = rs + 14'(r1);
      end
      for (int a = 0; a < int'(r5); a++)
         gen_line(int'(r4), int'(r9) + 1 + a, 1'b0, rs, 1'b0, int'(r0));
   endtask

   task automatic strobe(int n, int gap);
      for (int i = 0; i < n; i++) begin
         clk_en_i = 1'b1;
         @(posedge wb_clock_i); #1;
         clk_en_i = 1'b0;
         repeat (gap) begin @(posedge wb_clock_i); #1; end
      end
   endtask

   task automatic drain(string name);
      repeat (3) begin @(posedge wb_clock_i); #1; end
      check_int({name, "_leftover"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic set_small();
      r0 = 8'd7; r1 = 8'd4; r2 = 8'd5; r3h = 4'd2; r3v = 5'd3;
      r4 = 7'd2; r5 = 5'd1; r6 = 7'd2; r7 = 7'd2; r9 = 5'd1;
      start = 14'h1000;
   endtask

   task automatic apply_reset();
      wb_reset_i = 1'b1;
      clk_en_i   = 1'b0;
      @(posedge wb_clock_i); #1;
      @(posedge wb_clock_i); #1;
      check("reset", act_v, 24'd0);
      wb_reset_i = 1'b0;
      vs_left = 0;
      ls_cnt  = 0;
      fs_cnt  = 0;
   endtask

   // Capture whether the DUT took a strobe or a reset on this edge
   initial forever begin
      @(posedge wb_clock_i);
      en_seen  = clk_en_i && !wb_reset_i;
      rst_seen = wb_reset_i;
   end

   // Monitor: compare on every strobe, otherwise require outputs to hold with pulses low
   initial forever begin
      @(negedge wb_clock_i);
      if (mon_on) begin
         if (rst_seen) begin
            last_v = 24'd0;
         end else if (en_seen) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL underflow t=%0t: strobe with no expected entry", $time);
            end else begin
               check("strobe", act_v, exp_q.pop_front());
            end
            if (act_v[1]) ls_cnt++;
            if (act_v[0]) fs_cnt++;
            last_v = act_v;
         end else begin
            check("hold", act_v, {last_v[23:2], 2'b00});
         end
      end
   end

   initial begin
      wb_reset_i = 1'b1;
      clk_en_i   = 1'b0;
      set_small();
      @(posedge wb_clock_i); #1;
      mon_on = 1'b1;

      // Basic frame, strobe every cycle, two frames
      apply_reset();
      gen_frame(); gen_frame();
      strobe(112, 0);
      drain("basic");
      check_int("frame_starts", fs_cnt, 2);
      check_int("line_starts", ls_cnt, 14);

      // Strobe every 4th cycle
      apply_reset();
      gen_frame();
      strobe(56, 3);
      drain("sparse");
      check_int("sparse_frame_starts", fs_cnt, 1);

      // Long VSYNC spanning frames
      apply_reset();
      r3v = 5'd16;
      gen_frame(); gen_frame(); gen_frame(); gen_frame();
      strobe(224, 0);
      drain("vsync16");

      // No HSYNC, VSYNC row beyond the last row
      set_small();
      r3h = 4'd0; r7 = 7'd3;
      apply_reset();
      gen_frame();
      strobe(56, 0);
      drain("nosync");

      // No adjust lines: six lines per frame
      set_small();
      r5 = 5'd0;
      apply_reset();
      gen_frame(); gen_frame();
      strobe(96, 0);
      drain("noadj");
      check_int("noadj_line_starts", ls_cnt, 12);

      // Reduce R0 while h=6: next strobe wraps
      set_small();
      apply_reset();
      gen_line(0, 0, 1'b1, 14'h1000, 1'b1, 6);
      strobe(7, 0);
      r0 = 8'd3;
      gen_line(0, 1, 1'b1, 14'h1000, 1'b0, 3);
      gen_line(1, 0, 1'b1, 14'h1004, 1'b0, 3);
      gen_line(1, 1, 1'b1, 14'h1004, 1'b0, 3);
      gen_line(2, 0, 1'b1, 14'h1008, 1'b0, 3);
      gen_line(2, 1, 1'b1, 14'h1008, 1'b0, 3);
      gen_line(2, 2, 1'b0, 14'h100C, 1'b0, 3);
      gen_line(0, 0, 1'b1, 14'h1000, 1'b1, 0);
      strobe(25, 0);
      drain("r0_shrink");

      // Mid-frame start address change, new address wrapping past 0x3FFF
      set_small();
      apply_reset();
      gen_frame();
      strobe(20, 0);
      start = 14'h3FFE;
      strobe(36, 0);
      gen_frame();
      strobe(56, 0);
      drain("start_change");

      // Reset mid-frame with a simultaneous strobe
      set_small();
      apply_reset();
      gen_line(0, 0, 1'b1, 14'h1000, 1'b1, 7);
      gen_line(0, 1, 1'b1, 14'h1000, 1'b0, 7);
      gen_line(1, 0, 1'b1, 14'h1004, 1'b0, 7);
      strobe(24, 0);
      drain("pre_reset");
      wb_reset_i = 1'b1;
      clk_en_i   = 1'b1;
      @(posedge wb_clock_i); #1;
      check("midframe_reset", act_v, 24'd0);
      wb_reset_i = 1'b0;
      clk_en_i   = 1'b0;
      vs_left    = 0;
      gen_frame();
      strobe(56, 0);
      drain("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
